// File: rtl/screen_pkg.sv
// Shared types for the screen sequencer: displayed-screen ids, sequencer states
// and the full-brightness constant.
package screen_pkg;

    typedef enum logic [1:0] {
        SCR_START = 2'd0,
        SCR_PLAY  = 2'd1,
        SCR_OVER  = 2'd2
    } screen_e;

    typedef enum logic [1:0] {
        SHOW,
        FADE_OUT,
        FADE_IN
    } seq_state_e;

    localparam logic [4:0] BRIGHT_MAX = 5'd16;

endpackage

// File: rtl/rgb_fader.sv
// Combinational brightness scaling of a {r,g,b} 4:4:4 pixel by a 0..16 level.
// Each channel is (c * bright) >> 4, so 16 passes through and 0 is black.
module rgb_fader (
    input  logic [11:0] i_rgb,
    input  logic [4:0]  i_bright,
    output logic [11:0] o_rgb
);

    always_comb begin
        o_rgb = 12'd0;
        for (int ch = 0; ch < 3; ch++) begin
            o_rgb[ch*4 +: 4] = 4'((8'(i_rgb[ch*4 +: 4]) * 8'(i_bright)) >> 4);
        end
    end

endmodule

// File: rtl/screen_sequencer.sv
// Start/play/game-over sequencer with frame-synchronous fade-out/fade-in on every
// screen change; RGB path is registered, one vga_clk of latency, no backpressure.
module screen_sequencer
    import screen_pkg::*;
#(
    parameter int unsigned FADE_STEP_FRAMES = 1,
    parameter int unsigned H_ACTIVE         = 640,
    parameter int unsigned V_ACTIVE         = 480
) (
    input  logic        vga_clk,
    input  logic        reset,
    input  logic [9:0]  DrawX,
    input  logic [9:0]  DrawY,
    input  logic        blank,
    input  logic        start_pressed,
    input  logic        game_over,
    input  logic [11:0] start_rgb,
    input  logic [11:0] game_rgb,
    input  logic [11:0] over_rgb,
    output logic [3:0]  red,
    output logic [3:0]  green,
    output logic [3:0]  blue,
    output logic [1:0]  screen_id,
    output logic        game_enable,
    output logic        game_reset,
    output logic        fading
);

    localparam logic [7:0] STEP_LAST = 8'(FADE_STEP_FRAMES - 1);

    seq_state_e  r_state, w_state_nxt;
    screen_e     r_screen, w_screen_nxt;
    screen_e     r_target, w_target_nxt;
    logic [4:0]  r_bright, w_bright_nxt;
    logic [7:0]  r_step_cnt, w_step_nxt;
    logic        r_game_reset, w_game_reset_nxt;
    logic        w_fade_begin;

    logic        w_at_origin;
    logic        r_origin_d;
    logic        r_tick;
    logic        r_start_d;
    logic        r_start_req;
    logic        r_over_req;

    logic [11:0] w_src;
    logic [11:0] w_scaled;
    logic [11:0] r_rgb;

    // Edge-detected so a held (0,0) still yields one tick per frame.
    assign w_at_origin = (DrawX == 10'd0) && (DrawY == 10'd0);

    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            r_origin_d <= 1'b0;
            r_tick     <= 1'b0;
            r_start_d  <= 1'b0;
        end else begin
            r_origin_d <= w_at_origin;
            r_tick     <= w_at_origin & ~r_origin_d;
            r_start_d  <= start_pressed;
        end
    end

    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            r_start_req <= 1'b0;
            r_over_req  <= 1'b0;
        end else if (r_state != SHOW || w_fade_begin) begin
            r_start_req <= 1'b0;
            r_over_req  <= 1'b0;
        end else begin
            if (start_pressed && !r_start_d) r_start_req <= 1'b1;
            if (game_over && r_screen == SCR_PLAY) r_over_req <= 1'b1;
        end
    end

    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            r_state      <= SHOW;
            r_screen     <= SCR_START;
            r_target     <= SCR_PLAY;
            r_bright     <= BRIGHT_MAX;
            r_step_cnt   <= 8'd0;
            r_game_reset <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_screen     <= w_screen_nxt;
            r_target     <= w_target_nxt;
            r_bright     <= w_bright_nxt;
            r_step_cnt   <= w_step_nxt;
            r_game_reset <= w_game_reset_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_screen_nxt     = r_screen;
        w_target_nxt     = r_target;
        w_bright_nxt     = r_bright;
        w_step_nxt       = r_step_cnt;
        w_game_reset_nxt = 1'b0;
        w_fade_begin     = 1'b0;
        if (r_tick) begin
            case (r_state)
                SHOW: begin
                    if (r_screen == SCR_PLAY) begin
                        if (r_over_req) begin
                            w_fade_begin = 1'b1;
                            w_target_nxt = SCR_OVER;
                        end
                    end else if (r_start_req) begin
                        w_fade_begin = 1'b1;
                        w_target_nxt = SCR_PLAY;
                    end
                    if (w_fade_begin) begin
                        w_state_nxt = FADE_OUT;
                        w_step_nxt  = 8'd0;
                    end
                end
                FADE_OUT: begin
                    if (r_step_cnt == STEP_LAST) begin
                        w_step_nxt   = 8'd0;
                        w_bright_nxt = r_bright - 5'd1;
                        // Screen swaps at the black point, which is always a frame start.
                        if (r_bright == 5'd1) begin
                            w_state_nxt      = FADE_IN;
                            w_screen_nxt     = r_target;
                            w_game_reset_nxt = (r_target == SCR_PLAY);
                        end
                    end else begin
                        w_step_nxt = r_step_cnt + 8'd1;
                    end
                end
                FADE_IN: begin
                    if (r_step_cnt == STEP_LAST) begin
                        w_step_nxt   = 8'd0;
                        w_bright_nxt = r_bright + 5'd1;
                        if (r_bright == BRIGHT_MAX - 5'd1) w_state_nxt = SHOW;
                    end else begin
                        w_step_nxt = r_step_cnt + 8'd1;
                    end
                end
                default: w_state_nxt = SHOW;
            endcase
        end
    end

    always_comb begin
        fading      = (r_state != SHOW);
        game_enable = (r_state == SHOW) && (r_screen == SCR_PLAY);
    end

    assign screen_id  = r_screen;
    assign game_reset = r_game_reset;

    always_comb begin
        case (r_screen)
            SCR_PLAY: w_src = game_rgb;
            SCR_OVER: w_src = over_rgb;
            default:  w_src = start_rgb;
        endcase
    end

    rgb_fader u_fader (
        .i_rgb    (w_src),
        .i_bright (r_bright),
        .o_rgb    (w_scaled)
    );

    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) r_rgb <= 12'd0;
        else       r_rgb <= blank ? w_scaled : 12'd0;
    end

    assign {red, green, blue} = r_rgb;

    a_active_in_range: assert property (@(posedge vga_clk) disable iff (reset)
        blank |-> (32'(DrawX) < H_ACTIVE && 32'(DrawY) < V_ACTIVE));

endmodule
